// File: rtl/pc_branch_unit_if.sv
// Bundle between the control FSM / register file / fetch datapath and pc_branch_unit.
// master drives requests and operands; slave (the unit) drives PC, status and link outputs.
interface pc_branch_unit_if #(
  parameter int unsigned STAT_W = 16
);
  logic              Inc_PC;
  logic              Start;
  logic [15:0]       IR;
  logic              BEN;
  logic [15:0]       BaseR_data;
  logic [15:0]       PC;
  logic              Busy;
  logic              Done;
  logic              Taken;
  logic              R7_wr;
  logic [15:0]       R7_data;
  logic [STAT_W-1:0] Taken_Count;
  logic [STAT_W-1:0] Branch_Count;

  modport master (
    output Inc_PC, Start, IR, BEN, BaseR_data,
    input  PC, Busy, Done, Taken, R7_wr, R7_data, Taken_Count, Branch_Count
  );

  modport slave (
    input  Inc_PC, Start, IR, BEN, BaseR_data,
    output PC, Busy, Done, Taken, R7_wr, R7_data, Taken_Count, Branch_Count
  );
endinterface

// File: rtl/pc_branch_unit.sv
// LC-3 PC owner and BR/JMP/JSR/JSRR resolver: fixed IDLE->DECODE->ADDR->COMMIT sequence.
// Optional saturating statistics counters are built when BRANCH_STATS_EN is defined.
module pc_branch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned STAT_W   = 16
) (
  input logic             Clk,
  input logic             Reset,
  pc_branch_unit_if.slave bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDecode = 2'd1;
  localparam logic [1:0] StAddr   = 2'd2;
  localparam logic [1:0] StCommit = 2'd3;

  localparam logic [3:0] OpBr  = 4'b0000;
  localparam logic [3:0] OpJsr = 4'b0100;
  localparam logic [3:0] OpJmp = 4'b1100;

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        ben_q, ben_d;
  logic [15:0] base_q, base_d;
  logic [15:0] cap_pc_q, cap_pc_d;
  logic        taken_q, taken_d;
  logic        link_q, link_d;
  logic [15:0] target_q, target_d;
  logic [15:0] r7_q, r7_d;
  logic [15:0] pc_inc;
  logic        commit;

  assign pc_inc = pc_q + 16'd1;
  assign commit = (state_q == StCommit);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    ben_d    = ben_q;
    base_d   = base_q;
    cap_pc_d = cap_pc_q;
    taken_d  = taken_q;
    link_d   = link_q;
    target_d = target_q;
    r7_d     = r7_q;
    case (state_q)
      StIdle: begin
        if (bus.Inc_PC) pc_d = pc_inc;
        if (bus.Start) begin
          state_d  = StDecode;
          ir_d     = bus.IR;
          ben_d    = bus.BEN;
          base_d   = bus.BaseR_data;
          // Same-cycle Inc_PC: the captured return address is the incremented PC.
          cap_pc_d = pc_d;
        end
      end
      StDecode: begin
        state_d = StAddr;
        taken_d = 1'b0;
        link_d  = 1'b0;
        case (ir_q[15:12])
          OpBr:    taken_d = ben_q;
          OpJmp:   taken_d = 1'b1;
          OpJsr: begin
            taken_d = 1'b1;
            link_d  = 1'b1;
          end
          default: ;
        endcase
      end
      StAddr: begin
        state_d = StCommit;
        if (ir_q[15:12] == OpBr) begin
          target_d = cap_pc_q + {{7{ir_q[8]}}, ir_q[8:0]};
        end else if ((ir_q[15:12] == OpJsr) && ir_q[11]) begin
          target_d = cap_pc_q + {{5{ir_q[10]}}, ir_q[10:0]};
        end else begin
          target_d = base_q;
        end
        // R7_data must already be valid while R7_wr is high in COMMIT.
        if (link_q) r7_d = cap_pc_q;
      end
      StCommit: begin
        state_d = StIdle;
        if (taken_q) pc_d = target_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      ben_q    <= 1'b0;
      base_q   <= '0;
      cap_pc_q <= '0;
      taken_q  <= 1'b0;
      link_q   <= 1'b0;
      target_q <= '0;
      r7_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ben_q    <= ben_d;
      base_q   <= base_d;
      cap_pc_q <= cap_pc_d;
      taken_q  <= taken_d;
      link_q   <= link_d;
      target_q <= target_d;
      r7_q     <= r7_d;
    end
  end

  assign bus.PC      = pc_q;
  assign bus.Busy    = (state_q != StIdle);
  assign bus.Done    = commit;
  assign bus.Taken   = commit & taken_q;
  assign bus.R7_wr   = commit & link_q;
  assign bus.R7_data = r7_q;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] taken_cnt_q, branch_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      taken_cnt_q  <= '0;
      branch_cnt_q <= '0;
    end else if (commit) begin
      if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
      if (taken_q && (taken_cnt_q != '1)) taken_cnt_q <= taken_cnt_q + 1'b1;
    end
  end

  assign bus.Taken_Count  = taken_cnt_q;
  assign bus.Branch_Count = branch_cnt_q;
`else
  assign bus.Taken_Count  = '0;
  assign bus.Branch_Count = '0;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed vector table, hand sequences, random ops
// against a spec-level reference model.
module tb_pc_branch_unit;

  logic Clk = 1'b0;
  logic Reset;

  pc_branch_unit_if #(.STAT_W(16)) bus ();

  pc_branch_unit #(.RESET_PC(16'h0000), .STAT_W(16)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  // Reference model state
  logic [15:0] m_pc, m_r7, m_tc, m_bc;

  always @(negedge Clk) if (bus.Done === 1'b1) done_seen++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sext(input logic [15:0] v, input int bits);
    logic [15:0] r;
    r = v & ((16'd1 << bits) - 16'd1);
    if (v[bits-1]) r = r | ~((16'd1 << bits) - 16'd1);
    return r;
  endfunction

  // Spec-level classification and target computation.
  task automatic model_op(input logic [15:0] ir, input logic ben, input logic [15:0] base,
                          input logic [15:0] cap, output logic taken, output logic link,
                          output logic [15:0] tgt);
    taken = 1'b0; link = 1'b0; tgt = cap;
    if (ir[15:12] == 4'h0) begin
      taken = ben; tgt = cap + sext(ir, 9);
    end else if (ir[15:12] == 4'hC) begin
      taken = 1'b1; tgt = base;
    end else if (ir[15:12] == 4'h4) begin
      taken = 1'b1; link = 1'b1;
      tgt = ir[11] ? cap + sext(ir, 11) : base;
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic chk_counters();
`ifdef BRANCH_STATS_EN
    chk("taken_count", bus.Taken_Count, m_tc);
    chk("branch_count", bus.Branch_Count, m_bc);
`else
    chk("taken_count", bus.Taken_Count, 16'h0);
    chk("branch_count", bus.Branch_Count, 16'h0);
`endif
  endtask

  // One full Start..COMMIT transaction, checked cycle by cycle against the model.
  task automatic do_op(input logic [15:0] ir, input logic ben, input logic [15:0] base,
                       input bit inc, input bit inc_busy,
                       output logic o_taken, output logic o_link,
                       output logic [15:0] o_r7, output logic [15:0] o_pc);
    logic [15:0] cap, tgt, r7_exp;
    logic taken, link;
    @(negedge Clk);
    bus.IR = ir; bus.BEN = ben; bus.BaseR_data = base; bus.Start = 1'b1; bus.Inc_PC = inc;
    cap = inc ? m_pc + 16'd1 : m_pc;
    model_op(ir, ben, base, cap, taken, link, tgt);
    @(posedge Clk); #1;
    chk("busy_decode", bus.Busy, 1'b1);
    chk("pc_captured", bus.PC, cap);
    @(negedge Clk);
    bus.Start = 1'b0; bus.Inc_PC = inc_busy;
    bus.IR = 16'($urandom); bus.BEN = 1'($urandom); bus.BaseR_data = 16'($urandom);
    @(posedge Clk); #1;
    chk("done_addr", bus.Done, 1'b0);
    @(posedge Clk); #1;
    r7_exp = link ? cap : m_r7;
    chk("done_commit", bus.Done, 1'b1);
    chk("taken_commit", bus.Taken, taken);
    chk("r7wr_commit", bus.R7_wr, link);
    chk("r7data_commit", bus.R7_data, r7_exp);
    chk("pc_commit", bus.PC, cap);
    o_taken = bus.Taken; o_link = bus.R7_wr; o_r7 = bus.R7_data;
    m_r7 = r7_exp;
    m_pc = taken ? tgt : cap;
    m_bc = sat_inc(m_bc);
    if (taken) m_tc = sat_inc(m_tc);
    @(posedge Clk); #1;
    chk("pc_after", bus.PC, m_pc);
    chk("busy_after", bus.Busy, 1'b0);
    chk("done_after", bus.Done, 1'b0);
    chk_counters();
    o_pc = bus.PC;
    @(negedge Clk);
    bus.Inc_PC = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; bus.Start = 1'b0; bus.Inc_PC = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    m_pc = 16'h0000; m_r7 = 16'h0; m_tc = 16'h0; m_bc = 16'h0;
    chk("rst_pc", bus.PC, m_pc);
    chk("rst_busy", bus.Busy, 1'b0);
    chk("rst_done", bus.Done, 1'b0);
    chk("rst_taken", bus.Taken, 1'b0);
    chk("rst_r7wr", bus.R7_wr, 1'b0);
    chk("rst_r7data", bus.R7_data, m_r7);
    chk_counters();
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  typedef struct {
    logic [15:0] setup;
    logic [15:0] ir;
    logic        ben;
    logic [15:0] base;
    logic        exp_taken;
    logic        exp_link;
    logic [15:0] exp_pc;
    logic [15:0] exp_r7;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic t, l;
    logic [15:0] r7, pc;
    int d0;
    vecs[0] = '{16'h3001, 16'h0E05, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h3006, 16'h0};
    vecs[1] = '{16'h3001, 16'h0A10, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h3001, 16'h0};
    vecs[2] = '{16'h3010, 16'h4FFF, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h300F, 16'h3010};
    vecs[3] = '{16'h3006, 16'hC080, 1'b0, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 16'h0};
    vecs[4] = '{16'h2000, 16'h41C0, 1'b0, 16'h1234, 1'b1, 1'b1, 16'h1234, 16'h2000};
    vecs[5] = '{16'h0500, 16'h1234, 1'b1, 16'hAAAA, 1'b0, 1'b0, 16'h0500, 16'h0};
    vecs[6] = '{16'hFFFE, 16'h0E02, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0};
    vecs[7] = '{16'h4000, 16'h0003, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h4000, 16'h0};

    Reset = 1'b1;
    bus.Start = 1'b0; bus.Inc_PC = 1'b0; bus.IR = '0; bus.BEN = 1'b0; bus.BaseR_data = '0;
    do_reset();

    // Three increments, then Inc_PC held while busy must not move the PC.
    @(negedge Clk);
    bus.Inc_PC = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("inc_x3", bus.PC, 16'h0003);
    m_pc = 16'h0003;
    @(negedge Clk);
    bus.Inc_PC = 1'b0;
    do_op(16'h1000, 1'b0, 16'h0, 1'b0, 1'b1, t, l, r7, pc);
    chk("inc_busy_ignored", pc, 16'h0003);

    // Directed table; each entry first sets PC via JMP to the setup value.
    foreach (vecs[i]) begin
      do_op(16'hC000, 1'b0, vecs[i].setup, 1'b0, 1'b0, t, l, r7, pc);
      do_op(vecs[i].ir, vecs[i].ben, vecs[i].base, 1'b0, 1'b0, t, l, r7, pc);
      chk($sformatf("vec%0d_taken", i), t, vecs[i].exp_taken);
      chk($sformatf("vec%0d_link", i), l, vecs[i].exp_link);
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      if (vecs[i].exp_link) chk($sformatf("vec%0d_r7", i), r7, vecs[i].exp_r7);
    end

    // JMP to xFFFF then Inc_PC wraps to x0000.
    do_op(16'hC080, 1'b0, 16'hFFFF, 1'b0, 1'b0, t, l, r7, pc);
    @(negedge Clk);
    bus.Inc_PC = 1'b1;
    @(posedge Clk); #1;
    chk("inc_wrap", bus.PC, 16'h0000);
    m_pc = 16'h0000;
    @(negedge Clk);
    bus.Inc_PC = 1'b0;

    // Start with Inc_PC in the same cycle captures the incremented PC as link.
    do_op(16'h4802, 1'b0, 16'h0, 1'b1, 1'b0, t, l, r7, pc);
    chk("start_inc_link", r7, 16'h0001);
    chk("start_inc_pc", pc, 16'h0003);

    // Reset asserted while in ADDR aborts the sequence.
    do_op(16'h4FF0, 1'b0, 16'h0, 1'b0, 1'b0, t, l, r7, pc);
    d0 = done_seen;
    @(negedge Clk);
    bus.IR = 16'hC000; bus.BaseR_data = 16'h5555; bus.Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus.Start = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk("abort_busy", bus.Busy, 1'b0);
    chk("abort_pc", bus.PC, 16'h0000);
    chk("abort_done", bus.Done, 1'b0);
    chk("abort_r7wr", bus.R7_wr, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    chk("abort_no_done", done_seen - d0, 0);
    chk("abort_pc_hold", bus.PC, 16'h0000);
    m_pc = 16'h0000; m_r7 = 16'h0; m_tc = 16'h0; m_bc = 16'h0;
    chk_counters();

    // Start held into DECODE is ignored: exactly one Done, PC follows the first request.
    d0 = done_seen;
    @(negedge Clk);
    bus.IR = 16'hC000; bus.BaseR_data = 16'h0123; bus.Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus.BaseR_data = 16'h0456;
    @(posedge Clk);
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
    chk("start_busy_one_done", done_seen - d0, 1);
    chk("start_busy_pc", bus.PC, 16'h0123);
    m_pc = 16'h0123; m_bc = sat_inc(m_bc); m_tc = sat_inc(m_tc);

    // Randomised operations against the model.
    for (int n = 0; n < 150; n++) begin
      logic [15:0] ir;
      int sel;
      ir = 16'($urandom);
      sel = $urandom_range(0, 4);
      case (sel)
        0, 1: ir[15:12] = 4'h0;
        2: ir[15:12] = 4'hC;
        3: ir[15:12] = 4'h4;
        default: while (ir[15:12] == 4'h0 || ir[15:12] == 4'h4 || ir[15:12] == 4'hC)
          ir[15:12] = 4'($urandom);
      endcase
      do_op(ir, 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), t, l, r7, pc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
